// File: rtl/mux_nto1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_nto1_rr
//  Brief    : N-to-1 registered multiplexer with ready/valid handshakes.
//             Channel choice is either a fixed index (mode=0) or a
//             round-robin search starting at an internal pointer (mode=1).
//             One output register; it may reload in the same cycle it drains.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  grant
);

  // Output register and round-robin pointer
  logic [W-1:0]  out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] grant_q,     grant_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  // Selection helpers
  logic [SW:0]   rr_sum;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          sel_in_range;
  logic          fixed_ok;
  logic [SW-1:0] chosen;
  logic          chosen_ok;
  logic [W-1:0]  chosen_data;
  logic          reg_free;
  logic          xfer;
  logic [SW:0]   ptr_inc;

  // Round-robin search: first valid channel at ptr, ptr+1, ... wrapping at N
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    for (int k = 0; k < N; k++) begin
      rr_sum = {1'b0, ptr_q} + (SW+1)'(k);
      if (rr_sum >= (SW+1)'(N)) begin
        rr_sum = rr_sum - (SW+1)'(N);
      end
      if (!rr_found && in_valid[rr_sum[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[SW-1:0];
      end
    end
  end

  // Channel choice and handshake qualification; reset blocks every accept
  always_comb begin
    sel_in_range = ({1'b0, sel} < (SW+1)'(N));
    fixed_ok     = sel_in_range && in_valid[sel];
    chosen       = mode ? rr_idx   : sel;
    chosen_ok    = mode ? rr_found : fixed_ok;
    reg_free     = !out_valid_q || out_ready;
    xfer         = rst_n && reg_free && chosen_ok;
  end

  // One-hot accept strobe and data mux for the chosen channel
  always_comb begin
    in_ready    = '0;
    chosen_data = '0;
    for (int i = 0; i < N; i++) begin
      if (chosen == SW'(i)) begin
        in_ready[i] = xfer;
        chosen_data = in_data[i*W +: W];
      end
    end
  end

  // Next-state: load on transfer, empty on idle drain, otherwise hold
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    ptr_inc     = {1'b0, chosen} + (SW+1)'(1);
    if (ptr_inc >= (SW+1)'(N)) begin
      ptr_inc = '0;
    end
    if (xfer) begin
      out_data_d  = chosen_data;
      out_valid_d = 1'b1;
      grant_d     = chosen;
      // Only round-robin grants advance the pointer
      if (mode) begin
        ptr_d = ptr_inc[SW-1:0];
      end
    end else if (reg_free) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;

endmodule
`default_nettype wire
